// File: rtl/clkdiv_pkg.sv
// Shared definitions for the blink divider and the toggle period meter.
// The default timeout assumes the same 24 MHz system clock the divider uses.
package clkdiv_pkg;

  localparam int unsigned CNT_W = 32;

  localparam logic [CNT_W-1:0] TIMEOUT_CYC_DEF = 32'd24_000_000;
  localparam logic [CNT_W-1:0] CNT_ONE         = 32'd1;

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } meter_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by a history flop; flags any transition
// of the synchronized level as a single-cycle pulse.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_s,
  input  logic sig_i,
  output logic level_o,
  output logic edge_o
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk_i) begin
    if (rst_s) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], sig_i};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign level_o = r_sync[STAGES-1];
  assign edge_o  = r_sync[STAGES-1] ^ r_hist;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures cycles between successive transitions of an asynchronous toggling
// input; reports each interval with a valid strobe plus lock/timeout status.
module toggle_period_meter
  import clkdiv_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned      LOCK_COUNT  = 3
) (
  input  logic             clk_i,
  input  logic             rst_s,
  input  logic             sig_i,
  output logic [CNT_W-1:0] meas_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_COUNT);

  logic w_edge;

  meter_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_meas, w_meas_nxt;
  logic [CNT_W-1:0] r_match, w_match_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_timeout, w_timeout_nxt;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_i   (clk_i),
    .rst_s   (rst_s),
    .sig_i   (sig_i),
    .level_o (),
    .edge_o  (w_edge)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_meas_nxt    = r_meas;
    w_match_nxt   = r_match;
    w_valid_nxt   = 1'b0;
    w_locked_nxt  = r_locked;
    w_timeout_nxt = r_timeout;

    if (w_edge) begin
      w_cnt_nxt = CNT_ONE;
    end else if (r_cnt < TIMEOUT_CYC) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end

    case (r_state)
      ST_IDLE: begin
        // First edge only provides the reference point.
        if (w_edge) w_state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        // An edge on the threshold cycle takes priority over the timeout.
        if (w_edge) begin
          w_meas_nxt    = r_cnt;
          w_valid_nxt   = 1'b1;
          w_match_nxt   = (r_cnt == r_meas) ? sat_inc(r_match, LOCK_LIM) : CNT_ONE;
          w_locked_nxt  = (w_match_nxt >= LOCK_LIM);
          w_timeout_nxt = 1'b0;
        end else if (r_cnt == TIMEOUT_CYC) begin
          w_timeout_nxt = 1'b1;
          w_locked_nxt  = 1'b0;
          w_match_nxt   = '0;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_s) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_meas    <= '0;
      r_match   <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_meas    <= w_meas_nxt;
      r_match   <= w_match_nxt;
      r_valid   <= w_valid_nxt;
      r_locked  <= w_locked_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign meas_o    = r_meas;
  assign valid_o   = r_valid;
  assign locked_o  = r_locked;
  assign timeout_o = r_timeout;

endmodule
